// File: rtl/axis_packet_framer.sv
// axis_packet_framer: frames raw words into fixed-length AXI-Stream packets.
// Build option: define FRAMER_CHECKSUM_EN to append a mod-2^TDATAW sum flit.
//
// Ports:
//   CLK, RST            single clock, synchronous active-high reset
//   DEST_I              destination, sampled on the first payload word
//   IN_VALID/IN_READY   raw word handshake, IN_DATA carries the word
//   AXIS_M_*            registered AXI-Stream master (TVALID/TREADY/TDATA/
//                       TLAST/TDEST)
//   PKT_COUNT_O         completed packets, wraps at 16 bits
//   BUSY                high while a packet is partially sent
module axis_packet_framer #(
    parameter int TDATAW  = 32,
    parameter int TDESTW  = 4,
    parameter int PKT_LEN = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [TDESTW-1:0] DEST_I,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [TDATAW-1:0] IN_DATA,
    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TDESTW-1:0] AXIS_M_TDEST,
    output logic [15:0]       PKT_COUNT_O,
    output logic              BUSY
);

    localparam int CNTW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CKSUM
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNTW-1:0]   cnt;
    logic [CNTW-1:0]   cnt_nx;
    logic [CNTW-1:0]   idx;
    logic [TDESTW-1:0] dest;
    logic [TDESTW-1:0] dest_nx;
    logic              tvalid_nx;
    logic [TDATAW-1:0] tdata_nx;
    logic              tlast_nx;
    logic [TDESTW-1:0] tdest_nx;
    logic [15:0]       count_nx;
    logic              busy_nx;
    logic              load_ok;
    logic              in_fire;
    logic              out_fire;

`ifdef FRAMER_CHECKSUM_EN
    logic [TDATAW-1:0] sum;
    logic [TDATAW-1:0] sum_nx;
`endif

    // The holding register may be loaded when empty or draining this cycle.
    assign load_ok = !AXIS_M_TVALID || AXIS_M_TREADY;

`ifdef FRAMER_CHECKSUM_EN
    assign IN_READY = load_ok && (state != CKSUM) && !RST;
`else
    assign IN_READY = load_ok && !RST;
`endif

    assign in_fire  = IN_VALID && IN_READY;
    assign out_fire = AXIS_M_TVALID && AXIS_M_TREADY;

    // Index of the word being accepted; a new packet always starts at 0.
    assign idx = (state == IDLE) ? '0 : cnt;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        dest_nx   = dest;
        tvalid_nx = AXIS_M_TVALID;
        tdata_nx  = AXIS_M_TDATA;
        tlast_nx  = AXIS_M_TLAST;
        tdest_nx  = AXIS_M_TDEST;
        count_nx  = PKT_COUNT_O;
        busy_nx   = BUSY;
`ifdef FRAMER_CHECKSUM_EN
        sum_nx    = sum;
`endif

        if (out_fire) begin
            tvalid_nx = 1'b0;
            if (AXIS_M_TLAST) begin
                busy_nx  = 1'b0;
                count_nx = PKT_COUNT_O + 16'd1;
            end
        end

        // A load in the same cycle as a drain overrides the clear above,
        // so back-to-back flits leave no bubble.
        if (in_fire) begin
            tvalid_nx = 1'b1;
            tdata_nx  = IN_DATA;
            if (state == IDLE) begin
                dest_nx  = DEST_I;
                tdest_nx = DEST_I;
                busy_nx  = 1'b1;
            end else begin
                tdest_nx = dest;
            end
`ifdef FRAMER_CHECKSUM_EN
            sum_nx = (state == IDLE) ? IN_DATA : sum + IN_DATA;
`endif
            if (idx == LAST_IDX) begin
                cnt_nx = '0;
`ifdef FRAMER_CHECKSUM_EN
                tlast_nx = 1'b0;
                state_nx = CKSUM;
`else
                tlast_nx = 1'b1;
                state_nx = IDLE;
`endif
            end else begin
                cnt_nx   = idx + 1'b1;
                tlast_nx = 1'b0;
                state_nx = PAYLOAD;
            end
        end

`ifdef FRAMER_CHECKSUM_EN
        // The sum already includes the last payload word accepted on entry.
        if (state == CKSUM && load_ok) begin
            tvalid_nx = 1'b1;
            tdata_nx  = sum;
            tlast_nx  = 1'b1;
            tdest_nx  = dest;
            state_nx  = IDLE;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            cnt           <= '0;
            dest          <= '0;
            AXIS_M_TVALID <= 1'b0;
            AXIS_M_TDATA  <= '0;
            AXIS_M_TLAST  <= 1'b0;
            AXIS_M_TDEST  <= '0;
            PKT_COUNT_O   <= '0;
            BUSY          <= 1'b0;
`ifdef FRAMER_CHECKSUM_EN
            sum           <= '0;
`endif
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            dest          <= dest_nx;
            AXIS_M_TVALID <= tvalid_nx;
            AXIS_M_TDATA  <= tdata_nx;
            AXIS_M_TLAST  <= tlast_nx;
            AXIS_M_TDEST  <= tdest_nx;
            PKT_COUNT_O   <= count_nx;
            BUSY          <= busy_nx;
`ifdef FRAMER_CHECKSUM_EN
            sum           <= sum_nx;
`endif
        end
    end

endmodule

// File: tb/tb_axis_packet_framer.sv
// tb_axis_packet_framer: scoreboard bench for axis_packet_framer.
// Main instance uses PKT_LEN=4; a PKT_LEN=1 instance exercises count wrap.
module tb_axis_packet_framer;

    localparam int PKT_LEN = 4;
`ifdef FRAMER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  dest;
    } flit_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  DEST_I = '0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] IN_DATA = '0;
    logic        TVALID;
    logic        TREADY = 1'b1;
    logic [31:0] TDATA;
    logic        TLAST;
    logic [3:0]  TDEST;
    logic [15:0] PKT_COUNT;
    logic        BUSY;

    logic        v1 = 1'b0;
    logic        rdy1;
    logic [31:0] d1 = '0;
    logic        tready1 = 1'b1;
    logic        tv1;
    logic [31:0] td1;
    logic        tl1;
    logic [3:0]  tdst1;
    logic [15:0] cnt1;
    logic        busy1;

    flit_t       exp_q[$];
    flit_t       mon_e;
    int          hs_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          exp_cnt = 0;
    logic [31:0] sum_m = '0;
    bit          done = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    axis_packet_framer #(.TDATAW(32), .TDESTW(4), .PKT_LEN(PKT_LEN)) dut (
        .CLK(CLK), .RST(RST), .DEST_I(DEST_I),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .AXIS_M_TVALID(TVALID), .AXIS_M_TREADY(TREADY),
        .AXIS_M_TDATA(TDATA), .AXIS_M_TLAST(TLAST), .AXIS_M_TDEST(TDEST),
        .PKT_COUNT_O(PKT_COUNT), .BUSY(BUSY)
    );

    axis_packet_framer #(.TDATAW(32), .TDESTW(4), .PKT_LEN(1)) u_len1 (
        .CLK(CLK), .RST(RST), .DEST_I(4'd9),
        .IN_VALID(v1), .IN_READY(rdy1), .IN_DATA(d1),
        .AXIS_M_TVALID(tv1), .AXIS_M_TREADY(tready1),
        .AXIS_M_TDATA(td1), .AXIS_M_TLAST(tl1), .AXIS_M_TDEST(tdst1),
        .PKT_COUNT_O(cnt1), .BUSY(busy1)
    );

    // Output monitor: each handshake pops and checks one expected flit.
    always @(negedge CLK) begin
        if (!RST && TVALID && TREADY) begin
            hs_q.push_back(cyc);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_extra: got data=%h last=%b dest=%h, required no flit",
                         TDATA, TLAST, TDEST);
            end else begin
                mon_e = exp_q.pop_front();
                if ({TDATA, TLAST, TDEST} !== mon_e) begin
                    fails++;
                    $display("FAIL sb_flit: got data=%h last=%b dest=%h, required data=%h last=%b dest=%h",
                             TDATA, TLAST, TDEST, mon_e.data, mon_e.last, mon_e.dest);
                end
            end
        end
    end

    // Drive one word and record its expected flit(s) in the scoreboard.
    task automatic push_word(input logic [31:0] d, input logic [3:0] din,
                             input logic [3:0] pdest, input int i_word);
        flit_t f;
        bit ok;
        IN_VALID = 1'b1;
        IN_DATA  = d;
        DEST_I   = din;
        sum_m    = (i_word == 0) ? d : sum_m + d;
        f.data   = d;
        f.dest   = pdest;
        f.last   = (i_word == PKT_LEN - 1) && (CK == 0);
        exp_q.push_back(f);
        if (i_word == PKT_LEN - 1) begin
            if (CK != 0) begin
                f.data = sum_m;
                f.last = 1'b1;
                exp_q.push_back(f);
            end
            exp_cnt++;
        end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (IN_READY) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (ok) begin
            @(posedge CLK);
            #1;
        end else begin
            fails++;
            $display("FAIL in_timeout: got IN_READY=0 for 200 cycles, required 1");
        end
        IN_VALID = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge CLK);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        TREADY = 1'b1;
        IN_VALID = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        tests++;
        if (IN_READY !== 1'b0) begin
            fails++;
            $display("FAIL rst_in_ready: got %b, required 0", IN_READY);
        end
        tests++;
        if ({TVALID, TDATA, TLAST, TDEST, PKT_COUNT, BUSY} !== 55'd0) begin
            fails++;
            $display("FAIL rst_outputs: got v=%b d=%h l=%b dst=%h cnt=%0d busy=%b, required all 0",
                     TVALID, TDATA, TLAST, TDEST, PKT_COUNT, BUSY);
        end
        tests++;
        if ({tv1, cnt1, busy1} !== 18'd0) begin
            fails++;
            $display("FAIL rst_len1: got v=%b cnt=%0d busy=%b, required 0", tv1, cnt1, busy1);
        end
        IN_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
    endtask

    task automatic test_basic();
        int span;
        hs_q.delete();
        TREADY = 1'b1;
        push_word(32'd1, 4'd2, 4'd2, 0);
        tests++;
        if ({TVALID, TDATA, BUSY} !== {1'b1, 32'd1, 1'b1}) begin
            fails++;
            $display("FAIL latency: got v=%b d=%h busy=%b, required v=1 d=1 busy=1",
                     TVALID, TDATA, BUSY);
        end
        for (int i = 1; i < PKT_LEN; i++)
            push_word(32'(i + 1), 4'd2, 4'd2, i);
        wait_drain();
        span = (hs_q.size() > 0) ? hs_q[hs_q.size() - 1] - hs_q[0] : -1;
        tests++;
        if (hs_q.size() != PKT_LEN + CK || span != PKT_LEN + CK - 1) begin
            fails++;
            $display("FAIL basic_rate: got %0d flits over span %0d, required %0d over %0d",
                     hs_q.size(), span, PKT_LEN + CK, PKT_LEN + CK - 1);
        end
        tests++;
        if (PKT_COUNT !== 16'(exp_cnt) || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL basic_count: got cnt=%0d busy=%b, required cnt=%0d busy=0",
                     PKT_COUNT, BUSY, exp_cnt);
        end
    endtask

    task automatic test_stall();
        TREADY = 1'b1;
        push_word(32'd10, 4'd2, 4'd2, 0);
        push_word(32'd11, 4'd2, 4'd2, 1);
        TREADY = 1'b0;
        IN_VALID = 1'b1;
        IN_DATA = 32'd12;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            tests++;
            if ({TVALID, TDATA, TLAST, TDEST, IN_READY} !== {1'b1, 32'd11, 1'b0, 4'd2, 1'b0}) begin
                fails++;
                $display("FAIL stall_hold: got v=%b d=%h l=%b dst=%h rdy=%b, required v=1 d=b l=0 dst=2 rdy=0",
                         TVALID, TDATA, TLAST, TDEST, IN_READY);
            end
            @(posedge CLK);
            #1;
        end
        TREADY = 1'b1;
        push_word(32'd12, 4'd2, 4'd2, 2);
        push_word(32'd13, 4'd2, 4'd2, 3);
        wait_drain();
        tests++;
        if (exp_q.size() != 0 || PKT_COUNT !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL stall_drain: got left=%0d cnt=%0d, required left=0 cnt=%0d",
                     exp_q.size(), PKT_COUNT, exp_cnt);
        end
    endtask

    task automatic test_dest_change();
        TREADY = 1'b1;
        push_word(32'd20, 4'd2, 4'd2, 0);
        for (int i = 1; i < PKT_LEN; i++)
            push_word(32'(20 + i), 4'd3, 4'd2, i);
        for (int i = 0; i < PKT_LEN; i++)
            push_word(32'(30 + i), 4'd3, 4'd3, i);
        wait_drain();
        tests++;
        if (exp_q.size() != 0 || PKT_COUNT !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL dest_drain: got left=%0d cnt=%0d, required left=0 cnt=%0d",
                     exp_q.size(), PKT_COUNT, exp_cnt);
        end
    endtask

    task automatic test_checksum();
        logic exp_rdy;
        exp_rdy = (CK == 0);
        hs_q.delete();
        TREADY = 1'b1;
        push_word(32'hFFFF_FFFF, 4'd5, 4'd5, 0);
        push_word(32'd1, 4'd5, 4'd5, 1);
        push_word(32'd5, 4'd5, 4'd5, 2);
        push_word(32'd6, 4'd5, 4'd5, 3);
        @(negedge CLK);
        tests++;
        if (IN_READY !== exp_rdy) begin
            fails++;
            $display("FAIL cksum_ready: got %b, required %b", IN_READY, exp_rdy);
        end
        wait_drain();
        tests++;
        if (hs_q.size() != PKT_LEN + CK || PKT_COUNT !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL cksum_len: got %0d flits cnt=%0d, required %0d flits cnt=%0d",
                     hs_q.size(), PKT_COUNT, PKT_LEN + CK, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        TREADY = 1'b1;
        push_word(32'd40, 4'd6, 4'd6, 0);
        push_word(32'd41, 4'd6, 4'd6, 1);
        RST = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        @(negedge CLK);
        tests++;
        if (IN_READY !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_ready: got %b, required 0", IN_READY);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        tests++;
        if ({TVALID, TDATA, TLAST, TDEST, PKT_COUNT, BUSY} !== 55'd0) begin
            fails++;
            $display("FAIL rstmid_outputs: got v=%b d=%h l=%b dst=%h cnt=%0d busy=%b, required all 0",
                     TVALID, TDATA, TLAST, TDEST, PKT_COUNT, BUSY);
        end
        for (int i = 0; i < PKT_LEN; i++)
            push_word(32'(50 + i), 4'd7, 4'd7, i);
        wait_drain();
        tests++;
        if (exp_q.size() != 0 || PKT_COUNT !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL rstmid_next: got left=%0d cnt=%0d, required left=0 cnt=%0d",
                     exp_q.size(), PKT_COUNT, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pd;
        done = 1'b0;
        fork
            begin
                for (int p = 0; p < 3; p++) begin
                    pd = 4'($urandom_range(0, 15));
                    push_word($urandom, pd, pd, 0);
                    for (int i = 1; i < PKT_LEN; i++)
                        push_word($urandom, 4'($urandom_range(0, 15)), pd, i);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge CLK);
                    #2;
                    TREADY = 1'($urandom_range(0, 1));
                end
            end
        join
        TREADY = 1'b1;
        wait_drain();
        tests++;
        if (exp_q.size() != 0 || PKT_COUNT !== 16'(exp_cnt) || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: got left=%0d cnt=%0d busy=%b, required left=0 cnt=%0d busy=0",
                     exp_q.size(), PKT_COUNT, BUSY, exp_cnt);
        end
    endtask

    task automatic test_count_wrap();
        logic [15:0] n1;
        n1 = '0;
        v1 = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            d1 = 32'(i);
            @(posedge CLK);
            n1++;
            #1;
        end
        v1 = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        tests++;
        if (cnt1 !== n1 || n1 !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_pre: got %h, required %h", cnt1, n1);
        end
        v1 = 1'b1;
        @(posedge CLK);
        n1++;
        #1;
        v1 = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        tests++;
        if (cnt1 !== n1 || tv1 !== 1'b0 || busy1 !== 1'b0) begin
            fails++;
            $display("FAIL wrap_zero: got cnt=%h v=%b busy=%b, required cnt=%h v=0 busy=0",
                     cnt1, tv1, busy1, n1);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_dest_change();
        test_checksum();
        test_back_to_back();
        test_reset_mid();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
